cache_refill_axi: RTL and testbench



---
 rtl/cache_refill_axi_pkg.sv | 18 +
 rtl/cache_refill_axi_line_shift_buf.sv | 23 ++
 rtl/cache_refill_axi.sv | 116 +++++++++++
 tb/tb_cache_refill_axi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_axi_pkg.sv
// cache_refill_axi_pkg: shared line geometry, AXI burst constants and FSM states
package cache_refill_axi_pkg;
  localparam int CACHELINE_WIDTH = 512;
  localparam int WORD_WIDTH = 32;
  localparam int BEATS = CACHELINE_WIDTH / WORD_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFFSET_W = $clog2(CACHELINE_WIDTH / 8);
  localparam int TAG_W = 32 - OFFSET_W;
  localparam int ID_W = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN = 8'(BEATS - 1);
  localparam logic [2:0] AXI_SIZE = 3'($clog2(WORD_WIDTH / 8));
  localparam logic [ID_W-1:0] AXI_ID = '0;
  typedef enum logic [2:0] {IDLE, WB_CAP, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE} state_e;
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_refill_axi_line_shift_buf.sv
// line_shift_buf: cache-line buffer with a whole-line load and an indexed 32-bit word port
module line_shift_buf
  import cache_refill_axi_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic [CACHELINE_WIDTH-1:0] line_i,
  input  logic                       wr_i,
  input  logic [CNT_W-1:0]           idx_i,
  input  logic [WORD_WIDTH-1:0]      din_i,
  output logic [CACHELINE_WIDTH-1:0] line_o,
  output logic [WORD_WIDTH-1:0]      dout_o
);
  logic [CACHELINE_WIDTH-1:0] line_q;
  always_ff @(posedge clk) begin
    if (rst) line_q <= '0;
    else if (load_i) line_q <= line_i;
    else if (wr_i) line_q[idx_i*WORD_WIDTH +: WORD_WIDTH] <= din_i;
  end
  assign line_o = line_q;
  assign dout_o = line_q[idx_i*WORD_WIDTH +: WORD_WIDTH];
endmodule

// File: rtl/cache_refill_axi.sv
// cache_refill_axi: miss handler that writes back a dirty victim and refills a line over AXI4
module cache_refill_axi
  import cache_refill_axi_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic                       req_wb,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                wb_addr,
  input  logic [CACHELINE_WIDTH-1:0] cacheline_old,
  output logic                       refresh,
  output logic [CACHELINE_WIDTH-1:0] cacheline_new,
  output logic                       busy,
  output logic [31:0]                araddr,
  output logic                       arvalid,
  input  logic                       arready,
  output logic [ID_W-1:0]            arid,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  input  logic [WORD_WIDTH-1:0]      rdata,
  input  logic                       rvalid,
  input  logic                       rlast,
  output logic                       rready,
  output logic [31:0]                awaddr,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [ID_W-1:0]            awid,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic [WORD_WIDTH-1:0]      wdata,
  output logic                       wvalid,
  output logic                       wlast,
  input  logic                       wready,
  input  logic                       bvalid,
  output logic                       bready
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d, wb_tag_q, wb_tag_d;
  logic last_beat;
  logic [CACHELINE_WIDTH-1:0] wbuf_line_unused;
  logic [WORD_WIDTH-1:0] rbuf_word_unused;
  logic addr_unused;
  // line offsets are dropped, and completion is counted rather than taken from rlast
  assign addr_unused = ^{req_addr[OFFSET_W-1:0], wb_addr[OFFSET_W-1:0], rlast};
  assign last_beat = cnt_q == CNT_W'(BEATS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_tag_q <= '0;
      wb_tag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_tag_q <= req_tag_d;
      wb_tag_q <= wb_tag_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    req_tag_d = req_tag_q;
    wb_tag_d = wb_tag_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        req_tag_d = req_addr[31:OFFSET_W];
        wb_tag_d = wb_addr[31:OFFSET_W];
        state_d = req_wb ? WB_CAP : RD_AR;
      end
      WB_CAP: state_d = WB_AW;
      WB_AW: state_d = awready ? WB_W : WB_AW;
      WB_W: if (wready) begin
        cnt_d = cnt_q + 1'b1;
        state_d = last_beat ? WB_B : WB_W;
      end
      WB_B: state_d = bvalid ? RD_AR : WB_B;
      RD_AR: state_d = arready ? RD_R : RD_AR;
      RD_R: if (rvalid) begin
        cnt_d = cnt_q + 1'b1;
        state_d = last_beat ? DONE : RD_R;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE;
  assign refresh = state_q == DONE;
  assign awvalid = state_q == WB_AW;
  assign wvalid = state_q == WB_W;
  assign wlast = wvalid && last_beat;
  assign bready = state_q == WB_B;
  assign arvalid = state_q == RD_AR;
  assign rready = state_q == RD_R;
  assign awaddr = line_addr(wb_tag_q);
  assign araddr = line_addr(req_tag_q);
  assign {arid, awid} = {AXI_ID, AXI_ID};
  assign {arlen, awlen} = {AXI_LEN, AXI_LEN};
  assign {arsize, awsize} = {AXI_SIZE, AXI_SIZE};
  assign {arburst, awburst} = {AXI_BURST_INCR, AXI_BURST_INCR};
  line_shift_buf u_wbuf (
    .clk(clk), .rst(rst),
    .load_i(state_q == WB_CAP), .line_i(cacheline_old),
    .wr_i(1'b0), .idx_i(cnt_q), .din_i('0),
    .line_o(wbuf_line_unused), .dout_o(wdata)
  );
  line_shift_buf u_rbuf (
    .clk(clk), .rst(rst),
    .load_i(1'b0), .line_i('0),
    .wr_i(rready && rvalid), .idx_i(cnt_q), .din_i(rdata),
    .line_o(cacheline_new), .dout_o(rbuf_word_unused)
  );
endmodule

// File: tb/tb_cache_refill_axi.sv
// tb_cache_refill_axi: randomized AXI slave driving cache_refill_axi, checked against a line-level model
module tb_cache_refill_axi;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wb = 0;
  logic [31:0] req_addr = 0, wb_addr = 0;
  logic [511:0] cacheline_old = 0, cacheline_new;
  logic refresh, busy;
  logic [31:0] araddr, awaddr, wdata;
  logic [31:0] rdata = 0;
  logic arvalid, rready, awvalid, wvalid, wlast, bready;
  logic arready = 0, rvalid = 0, rlast = 0, awready = 0, wready = 0, bvalid = 0;
  logic [3:0] arid, awid;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  int checks = 0, failures = 0;
  logic [511:0] line_old_m, new_line;
  logic [31:0] rwords [16];
  logic [31:0] wq_data [20];
  logic wq_last [20];
  int wq_n, r_beats, aw_hs, ar_hs, b_hs, refresh_n, gap;
  logic [31:0] aw_addr_seen, ar_addr_seen;
  bit ar_before_b, stall_change, timeout, aborted;

  always #5 clk = ~clk;

  cache_refill_axi dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wb(req_wb), .req_addr(req_addr),
    .wb_addr(wb_addr), .cacheline_old(cacheline_old), .refresh(refresh),
    .cacheline_new(cacheline_new), .busy(busy), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready), .awaddr(awaddr),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [511:0] model_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = rwords[k];
    return l;
  endfunction

  function automatic logic [31:0] aligned(input logic [31:0] a);
    return a & 32'hFFFF_FFC0;
  endfunction

  // Plays the AXI slave and cache controller for one miss, recording what the DUT did
  task automatic run_txn(input bit wb, input logic [31:0] waddr, input logic [31:0] raddr,
                         input int wmode, input int rlast_beat, input int abort_beat,
                         input bit fast, input bit spam);
    int last_r = 0;
    bit prev_stall = 0, done = 0;
    logic [31:0] prev_wdata = 0;
    wq_n = 0; r_beats = 0; aw_hs = 0; ar_hs = 0; b_hs = 0; refresh_n = 0; gap = -1;
    ar_before_b = 0; stall_change = 0; timeout = 1; aborted = 0; new_line = 0;
    aw_addr_seen = 0; ar_addr_seen = 0;
    @(negedge clk);
    req_valid = 1; req_wb = wb; req_addr = raddr; wb_addr = waddr; cacheline_old = rand_line();
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; wb_addr = $urandom; cacheline_old = line_old_m;
    for (int c = 0; c < 800; c++) begin
      if (c == 1) cacheline_old = rand_line();
      if (refresh) begin
        refresh_n++; new_line = cacheline_new; gap = c - last_r; done = 1;
      end else if (done && !busy) begin
        timeout = 0; req_valid = 0; break;
      end
      req_valid = spam && busy;
      if (spam) begin req_wb = 1'($urandom_range(0, 1)); req_addr = $urandom; wb_addr = $urandom; end
      awready = fast ? 1'b1 : 1'($urandom_range(0, 1));
      if (awvalid && awready) begin aw_hs++; aw_addr_seen = awaddr; end
      if (arvalid && wb && b_hs == 0) ar_before_b = 1;
      bvalid = (wq_n >= 16 && b_hs == 0) ? (fast | bvalid | 1'($urandom_range(0, 1))) : 1'b0;
      if (bvalid && bready) b_hs++;
      wready = wmode == 0 ? 1'b1 : wmode == 1 ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      if (wvalid && prev_stall && wdata !== prev_wdata) stall_change = 1;
      if (wvalid && wready && wq_n < 20) begin
        wq_data[wq_n] = wdata; wq_last[wq_n] = wlast; wq_n++;
      end
      prev_stall = wvalid && !wready;
      prev_wdata = wdata;
      rvalid = (ar_hs > 0 && r_beats < 16) ? (fast | rvalid | 1'($urandom_range(0, 1))) : 1'b0;
      rdata = rvalid ? rwords[r_beats] : $urandom;
      rlast = rvalid && r_beats == rlast_beat;
      arready = fast ? 1'b1 : 1'($urandom_range(0, 1));
      if (arvalid && arready) begin ar_hs++; ar_addr_seen = araddr; end
      if (rvalid && rready) begin
        if (r_beats == abort_beat) begin rst = 1; aborted = 1; end
        r_beats++; last_r = c;
      end
      @(negedge clk);
      if (aborted) begin timeout = 0; break; end
    end
    req_valid = 0; bvalid = 0; rvalid = 0; rlast = 0; awready = 0; arready = 0; wready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, refresh, arvalid, rready, awvalid, wvalid, wlast, bready} !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl got=%b want=00000000",
        {busy, refresh, arvalid, rready, awvalid, wvalid, wlast, bready});
    end
    checks++;
    if ({cacheline_new, araddr, awaddr, wdata} !== '0) begin
      failures++; $display("FAIL reset_data got araddr=%h awaddr=%h wdata=%h line=%h",
        araddr, awaddr, wdata, cacheline_new[63:0]);
    end
    checks++;
    if ({arlen, arsize, arburst, arid, awlen, awsize, awburst, awid} !== {8'd15, 3'd2, 2'd1, 4'd0, 8'd15, 3'd2, 2'd1, 4'd0}) begin
      failures++; $display("FAIL burst_attr got arlen=%0d arsize=%0d arburst=%0d awlen=%0d want 15/2/1",
        arlen, arsize, arburst, awlen);
    end
    rst = 0;
  endtask

  task automatic test_clean_miss();
    logic [511:0] exp;
    for (int k = 0; k < 16; k++) rwords[k] = 32'h1000 + k;
    exp = model_line();
    run_txn(0, $urandom, 32'h8000_1234, 0, -1, -1, 1, 0);
    checks++; if (timeout) begin failures++; $display("FAIL clean_timeout got=1 want=0"); end
    checks++; if (refresh_n != 1) begin failures++; $display("FAIL clean_refresh_n got=%0d want=1", refresh_n); end
    checks++; if (gap != 1) begin failures++; $display("FAIL clean_refresh_gap got=%0d want=1", gap); end
    checks++; if (new_line[511:480] !== 32'h100F) begin failures++; $display("FAIL clean_word15 got=%h want=0000100f", new_line[511:480]); end
    checks++; if (new_line !== exp) begin failures++; $display("FAIL clean_line got=%h want=%h", new_line[127:0], exp[127:0]); end
    checks++; if (ar_addr_seen !== 32'h8000_1200) begin failures++; $display("FAIL clean_araddr got=%h want=80001200", ar_addr_seen); end
    checks++; if (aw_hs != 0 || wq_n != 0) begin failures++; $display("FAIL clean_no_write got aw=%0d w=%0d want 0/0", aw_hs, wq_n); end
    repeat (3) @(negedge clk);
    checks++; if (cacheline_new !== exp) begin failures++; $display("FAIL clean_line_stable got=%h want=%h", cacheline_new[127:0], exp[127:0]); end
  endtask

  task automatic test_dirty_miss();
    line_old_m = rand_line();
    for (int k = 0; k < 16; k++) rwords[k] = $urandom;
    run_txn(1, 32'h1FC0_0047, $urandom, 2, -1, -1, 0, 0);
    checks++; if (timeout) begin failures++; $display("FAIL dirty_timeout got=1 want=0"); end
    checks++; if (aw_addr_seen !== 32'h1FC0_0040 || aw_hs != 1) begin
      failures++; $display("FAIL dirty_awaddr got=%h (%0d hs) want=1fc00040 (1 hs)", aw_addr_seen, aw_hs); end
    checks++; if (wq_n != 16) begin failures++; $display("FAIL dirty_wbeats got=%0d want=16", wq_n); end
    for (int k = 0; k < 16 && k < wq_n; k++) begin
      checks++;
      if (wq_data[k] !== line_old_m[32*k +: 32] || wq_last[k] !== (k == 15)) begin
        failures++; $display("FAIL dirty_wbeat%0d got=%h last=%b want=%h last=%b",
          k, wq_data[k], wq_last[k], line_old_m[32*k +: 32], k == 15);
      end
    end
    checks++; if (ar_before_b) begin failures++; $display("FAIL dirty_ar_order got=ar_before_b want=ar_after_b"); end
    checks++; if (new_line !== model_line() || refresh_n != 1) begin
      failures++; $display("FAIL dirty_line got=%h n=%0d want=%h n=1", new_line[127:0], refresh_n, model_line()); end
  endtask

  task automatic test_backpressure();
    line_old_m = rand_line();
    for (int k = 0; k < 16; k++) rwords[k] = $urandom;
    run_txn(1, $urandom, $urandom, 1, -1, -1, 1, 0);
    checks++; if (stall_change) begin failures++; $display("FAIL bp_wdata_hold got=changed want=held"); end
    checks++; if (wq_n != 16) begin failures++; $display("FAIL bp_wbeats got=%0d want=16", wq_n); end
    for (int k = 0; k < 16 && k < wq_n; k++) begin
      checks++;
      if (wq_data[k] !== line_old_m[32*k +: 32]) begin
        failures++; $display("FAIL bp_wbeat%0d got=%h want=%h", k, wq_data[k], line_old_m[32*k +: 32]);
      end
    end
    checks++; if (new_line !== model_line()) begin failures++; $display("FAIL bp_line got=%h want=%h", new_line[127:0], model_line()); end
  endtask

  task automatic test_rlast_early();
    for (int k = 0; k < 16; k++) rwords[k] = $urandom;
    run_txn(0, $urandom, $urandom, 0, 3, -1, 0, 0);
    checks++; if (r_beats != 16 || refresh_n != 1) begin
      failures++; $display("FAIL rlast_beats got beats=%0d refresh=%0d want 16/1", r_beats, refresh_n); end
    checks++; if (gap != 1) begin failures++; $display("FAIL rlast_gap got=%0d want=1", gap); end
    checks++; if (new_line !== model_line()) begin failures++; $display("FAIL rlast_line got=%h want=%h", new_line[127:0], model_line()); end
  endtask

  task automatic test_reset_mid_read();
    int pulses = 0, busy_seen = 0;
    line_old_m = rand_line();
    for (int k = 0; k < 16; k++) rwords[k] = $urandom;
    run_txn(1, $urandom, $urandom, 2, -1, 7, 0, 0);
    checks++; if (!aborted) begin failures++; $display("FAIL rstmid_reached got=0 want=1"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++;
    if ({refresh, arvalid, rready, awvalid, wvalid, wlast, bready} !== 7'h00) begin
      failures++; $display("FAIL rstmid_valids got=%b want=0000000",
        {refresh, arvalid, rready, awvalid, wvalid, wlast, bready});
    end
    checks++;
    if ({cacheline_new, araddr, awaddr, wdata} !== '0) begin
      failures++; $display("FAIL rstmid_data got araddr=%h awaddr=%h wdata=%h line=%h",
        araddr, awaddr, wdata, cacheline_new[63:0]);
    end
    rst = 0;
    repeat (20) begin
      @(negedge clk);
      if (refresh) pulses++;
      if (busy) busy_seen++;
    end
    checks++; if (pulses != 0 || busy_seen != 0) begin
      failures++; $display("FAIL rstmid_quiet got refresh=%0d busy=%0d want 0/0", pulses, busy_seen); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] ra;
    ra = $urandom;
    for (int k = 0; k < 16; k++) rwords[k] = $urandom;
    run_txn(0, $urandom, ra, 2, -1, -1, 0, 1);
    checks++; if (refresh_n != 1 || ar_hs != 1 || aw_hs != 0) begin
      failures++; $display("FAIL ignore_counts got refresh=%0d ar=%0d aw=%0d want 1/1/0", refresh_n, ar_hs, aw_hs); end
    checks++; if (ar_addr_seen !== aligned(ra)) begin failures++; $display("FAIL ignore_araddr got=%h want=%h", ar_addr_seen, aligned(ra)); end
    checks++; if (new_line !== model_line()) begin failures++; $display("FAIL ignore_line got=%h want=%h", new_line[127:0], model_line()); end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      bit wb;
      logic [31:0] wa, ra;
      wb = 1'($urandom_range(0, 1)); wa = $urandom; ra = $urandom;
      line_old_m = rand_line();
      for (int k = 0; k < 16; k++) rwords[k] = $urandom;
      run_txn(wb, wa, ra, $urandom_range(0, 2), $urandom_range(0, 15), -1, 0, 0);
      checks++; if (timeout || refresh_n != 1 || new_line !== model_line()) begin
        failures++; $display("FAIL b2b%0d_line got=%h n=%0d to=%0d want=%h n=1", t, new_line[127:0], refresh_n, timeout, model_line()); end
      checks++; if (ar_addr_seen !== aligned(ra)) begin failures++; $display("FAIL b2b%0d_araddr got=%h want=%h", t, ar_addr_seen, aligned(ra)); end
      checks++; if (wq_n != (wb ? 16 : 0) || (wb && aw_addr_seen !== aligned(wa))) begin
        failures++; $display("FAIL b2b%0d_write got beats=%0d awaddr=%h want beats=%0d awaddr=%h", t, wq_n, aw_addr_seen, wb ? 16 : 0, aligned(wa)); end
      for (int k = 0; k < 16 && k < wq_n; k++) begin
        checks++;
        if (wq_data[k] !== line_old_m[32*k +: 32]) begin
          failures++; $display("FAIL b2b%0d_wbeat%0d got=%h want=%h", t, k, wq_data[k], line_old_m[32*k +: 32]);
        end
      end
    end
  endtask

  initial begin
    line_old_m = 0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_rlast_early();
    test_reset_mid_read();
    test_busy_ignore();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
